// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one ALU. Requests are granted
// round-robin, the winner's operands are registered onto the ALU inputs, the
// ALU result is captured ALU_LAT cycles later, and it is returned to the
// owner over a valid/ready response channel.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int SEL_W   = 3,
    parameter int ALU_LAT = 1     // legal range 1..4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       Req_Valid,
    output logic [1:0]       Req_Ready,
    input  logic [WIDTH-1:0] Req_A0,
    input  logic [WIDTH-1:0] Req_B0,
    input  logic [SEL_W-1:0] Req_Sel0,
    input  logic [WIDTH-1:0] Req_A1,
    input  logic [WIDTH-1:0] Req_B1,
    input  logic [SEL_W-1:0] Req_Sel1,
    output logic [1:0]       Rsp_Valid,
    input  logic [1:0]       Rsp_Ready,
    output logic [WIDTH-1:0] Rsp_Data,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [SEL_W-1:0] ALUSel,
    input  logic [WIDTH-1:0] ALU_Output,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_prio;       // requester that wins a tie
    logic             r_owner;      // requester of the transaction in flight
    logic [2:0]       r_cnt;        // remaining ALU latency cycles
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [SEL_W-1:0] r_alu_sel;
    logic [WIDTH-1:0] r_rsp_data;
    logic [1:0]       r_rsp_valid;
    logic             w_win;        // arbitration winner (meaningful only if any request)
    logic             w_accept;     // request handshake happens on this edge

    // Arbitration: a lone requester wins outright, a tie goes to the priority holder.
    always_comb begin
        w_win = 1'b0;
        if (Req_Valid == 2'b11) begin
            w_win = r_prio;
        end else begin
            w_win = Req_Valid[1];
        end
    end

    // Next-state and request-accept decode; Req_Ready is purely combinational in IDLE.
    always_comb begin
        w_state_next = r_state;
        Req_Ready    = 2'b00;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (Req_Valid != 2'b00) begin
                    Req_Ready    = w_win ? 2'b10 : 2'b01;
                    w_accept     = 1'b1;
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                if (r_cnt == 3'd1) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                // Only the owner's response accept matters.
                if (Rsp_Ready[r_owner]) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the winner's operands on the handshake; they hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_owner   <= 1'b0;
        end else if (w_accept) begin
            r_alu_a   <= w_win ? Req_A1   : Req_A0;
            r_alu_b   <= w_win ? Req_B1   : Req_B0;
            r_alu_sel <= w_win ? Req_Sel1 : Req_Sel0;
            r_owner   <= w_win;
        end
    end

    // Latency counter: loaded on accept, counts down while the ALU settles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if (w_accept) begin
            r_cnt <= 3'(ALU_LAT);
        end else if (r_state == EXEC) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // Response channel: sample the ALU once, then hold until the owner takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= 2'b00;
        end else if (r_state == EXEC && r_cnt == 3'd1) begin
            r_rsp_data  <= ALU_Output;
            r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
        end else if (r_state == RESP && Rsp_Ready[r_owner]) begin
            r_rsp_valid <= 2'b00;
        end
    end

    // Round-robin pointer: after serving a requester, the other one gets the tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (r_state == RESP && Rsp_Ready[r_owner]) begin
            r_prio <= ~r_owner;
        end
    end

    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign ALUSel    = r_alu_sel;
    assign Rsp_Data  = r_rsp_data;
    assign Rsp_Valid = r_rsp_valid;
    assign Busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one instance with ALU_LAT=1 and one with ALU_LAT=3,
// each fed by a small behavioural ALU. Expected responses are queued at grant
// time and compared when the owner accepts a response.
module tb_alu_arbiter;

    logic clk;
    int   n_tests = 0;
    int   n_fail  = 0;

    // ---------------- instance with ALU_LAT = 1 ----------------
    logic        rst_1;
    logic [1:0]  req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1;
    logic [31:0] a0_1, b0_1, a1_1, b1_1, rsp_data_1, alu_a_1, alu_b_1, alu_out_1;
    logic [2:0]  sel0_1, sel1_1, alu_sel_1;
    logic        busy_1;

    // ---------------- instance with ALU_LAT = 3 ----------------
    logic        rst_3;
    logic [1:0]  req_valid_3, req_ready_3, rsp_valid_3, rsp_ready_3;
    logic [31:0] a0_3, b0_3, a1_3, b1_3, rsp_data_3, alu_a_3, alu_b_3, alu_out_3;
    logic [2:0]  sel0_3, sel1_3, alu_sel_3;
    logic        busy_3;
    logic [31:0] noise_3;   // corrupts the ALU output except in the cycle it should be sampled

    logic [33:0] q1[$];
    logic [33:0] q3[$];
    logic [33:0] e1, e3;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] sel);
        case (sel)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out_1 = alu_f(alu_a_1, alu_b_1, alu_sel_1);
    assign alu_out_3 = alu_f(alu_a_3, alu_b_3, alu_sel_3) ^ noise_3;

    alu_arbiter #(.WIDTH(32), .SEL_W(3), .ALU_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst_1),
        .Req_Valid(req_valid_1), .Req_Ready(req_ready_1),
        .Req_A0(a0_1), .Req_B0(b0_1), .Req_Sel0(sel0_1),
        .Req_A1(a1_1), .Req_B1(b1_1), .Req_Sel1(sel1_1),
        .Rsp_Valid(rsp_valid_1), .Rsp_Ready(rsp_ready_1), .Rsp_Data(rsp_data_1),
        .ALU_A(alu_a_1), .ALU_B(alu_b_1), .ALUSel(alu_sel_1),
        .ALU_Output(alu_out_1), .Busy(busy_1)
    );

    alu_arbiter #(.WIDTH(32), .SEL_W(3), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst_3),
        .Req_Valid(req_valid_3), .Req_Ready(req_ready_3),
        .Req_A0(a0_3), .Req_B0(b0_3), .Req_Sel0(sel0_3),
        .Req_A1(a1_3), .Req_B1(b1_3), .Req_Sel1(sel1_3),
        .Rsp_Valid(rsp_valid_3), .Rsp_Ready(rsp_ready_3), .Rsp_Data(rsp_data_3),
        .ALU_A(alu_a_3), .ALU_B(alu_b_3), .ALUSel(alu_sel_3),
        .ALU_Output(alu_out_3), .Busy(busy_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] rdy(input int d);
        return (d == 1) ? req_ready_1 : req_ready_3;
    endfunction

    function automatic int qsize(input int d);
        return (d == 1) ? q1.size() : q3.size();
    endfunction

    // Wait (bounded) for a grant, check which requester got it, queue the expected response.
    task automatic wait_grant(input int d, input logic [1:0] exp, input logic [31:0] data,
                              input string tag);
        int n = 0;
        while (rdy(d) == 2'b00 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val(tag, {62'd0, rdy(d)}, {62'd0, exp});
        if (d == 1) q1.push_back({exp, data});
        else        q3.push_back({exp, data});
    endtask

    // Wait (bounded) until every queued response has been delivered.
    task automatic drain(input int d, input string tag);
        int n = 0;
        while (qsize(d) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 64'(qsize(d)), 64'd0);
    endtask

    // Response scoreboards: compare on every response handshake.
    always @(negedge clk) begin
        #2;
        if ((rsp_valid_1 & rsp_ready_1) != 2'b00) begin
            if (q1.size() == 0) begin
                check_val("d1_rsp_unexpected", {30'd0, rsp_valid_1, rsp_data_1}, 64'd0);
            end else begin
                e1 = q1.pop_front();
                check_val("d1_rsp", {30'd0, rsp_valid_1, rsp_data_1}, {30'd0, e1});
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if ((rsp_valid_3 & rsp_ready_3) != 2'b00) begin
            if (q3.size() == 0) begin
                check_val("d3_rsp_unexpected", {30'd0, rsp_valid_3, rsp_data_3}, 64'd0);
            end else begin
                e3 = q3.pop_front();
                check_val("d3_rsp", {30'd0, rsp_valid_3, rsp_data_3}, {30'd0, e3});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_1 = 1'b1; rst_3 = 1'b1;
        req_valid_1 = 2'b00; rsp_ready_1 = 2'b00;
        a0_1 = '0; b0_1 = '0; sel0_1 = '0; a1_1 = '0; b1_1 = '0; sel1_1 = '0;
        req_valid_3 = 2'b00; rsp_ready_3 = 2'b00;
        a0_3 = '0; b0_3 = '0; sel0_3 = '0; a1_3 = '0; b1_3 = '0; sel1_3 = '0;
        noise_3 = '0;
        repeat (2) @(negedge clk);
        rst_1 = 1'b0; rst_3 = 1'b0;
        #1;
        check_val("por_busy", {63'd0, busy_1}, 64'd0);
        check_val("por_rsp_valid", {62'd0, rsp_valid_1}, 64'd0);
        @(negedge clk);

        // ---- single request from requester 0, ALU_LAT=1 ----
        req_valid_1 = 2'b01; a0_1 = 32'h0000F0AF; b0_1 = 32'h0F0FF034; sel0_1 = 3'b000;
        #1;
        check_val("t2_ready", {62'd0, req_ready_1}, 64'd1);
        check_val("t2_busy_idle", {63'd0, busy_1}, 64'd0);
        q1.push_back({2'b01, 32'h0000F024});
        @(negedge clk);
        req_valid_1 = 2'b00;
        #1;
        check_val("t2_alu_a", {32'd0, alu_a_1}, 64'h0000F0AF);
        check_val("t2_alu_b", {32'd0, alu_b_1}, 64'h0F0FF034);
        check_val("t2_alu_sel", {61'd0, alu_sel_1}, 64'd0);
        check_val("t2_busy_exec", {63'd0, busy_1}, 64'd1);
        check_val("t2_no_rsp_yet", {62'd0, rsp_valid_1}, 64'd0);
        @(negedge clk);
        #1;
        check_val("t2_rsp_valid", {62'd0, rsp_valid_1}, 64'd1);
        check_val("t2_rsp_data", {32'd0, rsp_data_1}, 64'h0000F024);

        // ---- asynchronous reset in the middle of a cycle, response still pending ----
        #2;
        rst_1 = 1'b1;
        #1;
        check_val("t1_alu_a", {32'd0, alu_a_1}, 64'd0);
        check_val("t1_alu_b", {32'd0, alu_b_1}, 64'd0);
        check_val("t1_alu_sel", {61'd0, alu_sel_1}, 64'd0);
        check_val("t1_rsp_data", {32'd0, rsp_data_1}, 64'd0);
        check_val("t1_rsp_valid", {62'd0, rsp_valid_1}, 64'd0);
        check_val("t1_busy", {63'd0, busy_1}, 64'd0);
        check_val("t1_req_ready", {62'd0, req_ready_1}, 64'd0);
        void'(q1.pop_back());   // that transaction is dropped by the reset
        @(negedge clk);
        rst_1 = 1'b0;

        // ---- both requesters valid continuously: grants must alternate ----
        req_valid_1 = 2'b11; rsp_ready_1 = 2'b11;
        a0_1 = 32'd14; b0_1 = 32'd3; sel0_1 = 3'b010;
        a1_1 = 32'h0000F0DF; b1_1 = 32'hF030F285; sel1_1 = 3'b001;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k % 2 == 0) wait_grant(1, 2'b01, 32'd17, "t3_grant0");
            else            wait_grant(1, 2'b10, 32'hF030F2DF, "t3_grant1");
            @(negedge clk);
        end
        req_valid_1 = 2'b00;
        drain(1, "t3_drain");

        // ---- response backpressure; non-owner Rsp_Ready must be ignored ----
        @(negedge clk);
        req_valid_1 = 2'b11; rsp_ready_1 = 2'b10;
        a0_1 = 32'd5; b0_1 = 32'd6; sel0_1 = 3'b010;
        #1;
        wait_grant(1, 2'b01, 32'd11, "t4_grant");
        @(negedge clk);
        req_valid_1 = 2'b10;
        #1;
        begin
            int n = 0;
            while (rsp_valid_1 == 2'b00 && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check_val("t4_hold_valid", {62'd0, rsp_valid_1}, 64'd1);
            check_val("t4_hold_data", {32'd0, rsp_data_1}, 64'd11);
            check_val("t4_hold_ready", {62'd0, req_ready_1}, 64'd0);
            check_val("t4_hold_busy", {63'd0, busy_1}, 64'd1);
            @(negedge clk);
            #1;
        end
        rsp_ready_1 = 2'b01;
        @(negedge clk);
        #1;
        check_val("t4_next_grant", {62'd0, req_ready_1}, 64'd2);
        wait_grant(1, 2'b10, 32'hF030F2DF, "t4_req1");
        @(negedge clk);
        req_valid_1 = 2'b00; rsp_ready_1 = 2'b11;
        drain(1, "t4_drain");

        // ---- ALU_LAT=3: response exactly three edges after the handshake ----
        @(negedge clk);
        req_valid_3 = 2'b01; rsp_ready_3 = 2'b01;
        a0_3 = 32'hFF; b0_3 = 32'hFF; sel0_3 = 3'b010;
        noise_3 = 32'hDEAD0000;
        #1;
        wait_grant(3, 2'b01, 32'h1FE, "t5_grant");
        @(negedge clk);
        req_valid_3 = 2'b00;
        #1;
        check_val("t5_alu_a", {32'd0, alu_a_3}, 64'hFF);
        check_val("t5_busy", {63'd0, busy_3}, 64'd1);
        check_val("t5_rsp_e1", {62'd0, rsp_valid_3}, 64'd0);
        @(negedge clk);
        #1;
        check_val("t5_rsp_e2", {62'd0, rsp_valid_3}, 64'd0);
        @(negedge clk);
        noise_3 = 32'd0;
        #1;
        check_val("t5_rsp_e2b", {62'd0, rsp_valid_3}, 64'd0);
        check_val("t5_busy_late", {63'd0, busy_3}, 64'd1);
        @(negedge clk);
        #1;
        check_val("t5_rsp_e3", {62'd0, rsp_valid_3}, 64'd1);
        check_val("t5_rsp_data", {32'd0, rsp_data_3}, 64'h1FE);

        // ---- reset during EXEC drops the transaction and clears the priority ----
        @(negedge clk);
        req_valid_3 = 2'b01; rsp_ready_3 = 2'b11;
        a0_3 = 32'd1; b0_3 = 32'd2; sel0_3 = 3'b010;
        #1;
        wait_grant(3, 2'b01, 32'd3, "t6_grant");
        @(negedge clk);
        req_valid_3 = 2'b00;
        @(negedge clk);
        #3;
        rst_3 = 1'b1;
        #1;
        check_val("t6_rst_busy", {63'd0, busy_3}, 64'd0);
        check_val("t6_rst_rsp", {62'd0, rsp_valid_3}, 64'd0);
        void'(q3.pop_back());
        @(negedge clk);
        rst_3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("t6_no_rsp", {62'd0, rsp_valid_3}, 64'd0);
            check_val("t6_idle", {63'd0, busy_3}, 64'd0);
            @(negedge clk);
        end
        req_valid_3 = 2'b11;
        a1_3 = 32'h0000F0DF; b1_3 = 32'hF030F285; sel1_3 = 3'b001;
        #1;
        wait_grant(3, 2'b01, 32'd3, "t6_prio_reset");
        @(negedge clk);
        req_valid_3 = 2'b10;
        #1;
        wait_grant(3, 2'b10, 32'hF030F2DF, "t6_req1");
        @(negedge clk);
        req_valid_3 = 2'b00;
        drain(3, "t6_drain");

        check_val("q1_empty", 64'(q1.size()), 64'd0);
        check_val("q3_empty", 64'(q3.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
